// File: rtl/match_event_logger.sv
// match_event_logger
//   Logs match events from a sequence detector. Each cycle with en && q is one
//   event: the free-running cycle timer value is pushed into a small timestamp
//   FIFO and a saturating match counter advances. Timestamps are drained over
//   a valid/ready interface.
//
// Ports
//   clk         : clock, all state changes on posedge
//   reset       : synchronous active-high reset, clears everything incl. timer
//   q           : detector match output
//   en          : logging enable (q ignored when low)
//   clr         : synchronous clear of FIFO, counter and overflow (not timer)
//   ts_valid    : FIFO non-empty
//   ts_ready    : consumer accepts ts_data when ts_valid && ts_ready
//   ts_data     : oldest stored timestamp (registered)
//   fifo_level  : current FIFO occupancy 0..DEPTH
//   match_count : events since reset/clr, saturating
//   overflow    : sticky, set when an event is dropped on a full FIFO
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       q,
  input  logic                       en,
  input  logic                       clr,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [TS_W-1:0]            ts_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [CNT_W-1:0]           match_count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [TS_W-1:0]  timer_reg;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] head_succ;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic [TS_W-1:0]  ts_data_reg, ts_data_next;
  logic             event_hit, do_pop, do_push, do_drop;

  always_comb begin
    // clr discards any event and any handshake in the same cycle
    event_hit = en & q & ~clr;
    do_pop    = (level_reg != '0) & ts_ready & ~clr;
    // a full FIFO still accepts when the head leaves in the same cycle
    do_push   = event_hit & ((level_reg != LVL_FULL) | do_pop);
    do_drop   = event_hit & ~do_push;
    head_succ = rd_ptr_reg + PTR_W'(1);

    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    level_next   = level_reg;
    count_next   = count_reg;
    ovf_next     = ovf_reg;
    ts_data_next = ts_data_reg;

    if (clr) begin
      rd_ptr_next  = '0;
      wr_ptr_next  = '0;
      level_next   = '0;
      count_next   = '0;
      ovf_next     = 1'b0;
      ts_data_next = '0;
    end else begin
      if (do_pop)  rd_ptr_next = head_succ;
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);

      case ({do_push, do_pop})
        2'b10:   level_next = level_reg + LVL_W'(1);
        2'b01:   level_next = level_reg - LVL_W'(1);
        default: level_next = level_reg;
      endcase

      if (event_hit && count_reg != CNT_MAX) count_next = count_reg + CNT_W'(1);
      if (do_drop) ovf_next = 1'b1;

      // ts_data is a registered copy of the head. It only changes when the
      // head leaves, or when the first entry lands in an empty FIFO. With a
      // single entry being popped, the successor slot is the one being written
      // right now, so the incoming timestamp is forwarded directly.
      if (do_pop) begin
        if (level_reg != LVL_ONE) ts_data_next = mem[head_succ];
        else if (do_push)         ts_data_next = timer_reg;
      end else if (level_reg == '0 && do_push) begin
        ts_data_next = timer_reg;
      end
    end
  end

  // Timestamp storage, no reset needed: contents are only read behind level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= timer_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      level_reg   <= '0;
      count_reg   <= '0;
      ovf_reg     <= 1'b0;
      ts_data_reg <= '0;
    end else begin
      timer_reg   <= timer_reg + TS_W'(1);
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      level_reg   <= level_next;
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
      ts_data_reg <= ts_data_next;
    end
  end

  assign ts_valid    = (level_reg != '0);
  assign ts_data     = ts_data_reg;
  assign fifo_level  = level_reg;
  assign match_count = count_reg;
  assign overflow    = ovf_reg;

endmodule
